delayed_coef_multiplier: RTL and testbench



---
 rtl/delayed_coef_multiplier_pkg.sv | 14 +
 rtl/delayed_coef_multiplier_if.sv | 15 +
 rtl/delayed_coef_multiplier_delay_line.sv | 37 +++
 rtl/delayed_coef_multiplier.sv | 105 ++++++++++
 tb/tb_delayed_coef_multiplier.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/delayed_coef_multiplier_pkg.sv
// Shared constants and types for the DCT coefficient-multiplier tap.
// Optional build macro used by the top: DCT_ROUND_EN (round half up before scaling).
package dct_pkg;

  // Default sample / coefficient / product width
  localparam int DCT_DATA_WIDTH = 10;

  // Fixed-point scale of a Q1.(W-1) coefficient: 1.0 == 2^(W-1)
  localparam int DCT_COEF_SCALE = 32'sd1 <<< (DCT_DATA_WIDTH - 32'sd1);

  // Signed sample at the default width
  typedef logic signed [DCT_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/delayed_coef_multiplier_if.sv
// Coefficient ROM read port: en/addr from the requester, data back combinationally.
// tx = requester side (drives en/addr), rx = ROM side (drives data).
interface rom_if
  import dct_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = DCT_DATA_WIDTH
);
  logic                         en;
  logic        [ADDR_WIDTH-1:0] addr;
  logic signed [DATA_WIDTH-1:0] data;

  modport tx (output en, output addr, input data);
  modport rx (input en, input addr, output data);
endinterface

// File: rtl/delayed_coef_multiplier_delay_line.sv
// Fixed-length shift register; DEPTH=0 degenerates to a wire.
// All stages shift every cycle and clear on reset.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift the pipe one stage per cycle, flushing on reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
          end
        end else begin
          stage_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign q = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/delayed_coef_multiplier.sv
// DCT datapath tap: delays the sample stream, fetches one coefficient per
// delayed valid sample from a ROM and registers the Q1.(W-1) scaled product.
// Optional macro DCT_ROUND_EN: add half an LSB before the scaling shift.
module delayed_coef_multiplier
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_DATA_WIDTH,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic signed [DATA_WIDTH-1:0] dly_data,
  output logic                         dly_valid,
  rom_if.tx                            rom,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid
);

  localparam int PW = 2 * DATA_WIDTH;

  // Largest representable result, widened to product width for the compare
  localparam logic signed [PW-1:0] SAT_MAX_P =
    {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX_W =
    {1'b0, {(DATA_WIDTH - 1){1'b1}}};

`ifdef DCT_ROUND_EN
  // Half of one output LSB in product scale: 2^(W-2)
  localparam logic signed [PW-1:0] ROUND_BIAS =
    {{(DATA_WIDTH + 1){1'b0}}, 1'b1, {(DATA_WIDTH - 2){1'b0}}};
`endif

  logic [DATA_WIDTH:0]          dly_bus_s;
  logic [ADDR_WIDTH-1:0]        addr_cnt_r;
  logic signed [PW-1:0]         prod_s;
  logic signed [PW-1:0]         biased_s;
  logic signed [PW-1:0]         shifted_s;
  logic signed [DATA_WIDTH-1:0] scaled_s;

  // {data, valid} travel together so valid always qualifies its own sample
  delay_line #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({in_data, in_valid}),
    .q     (dly_bus_s)
  );

  assign dly_data  = dly_bus_s[DATA_WIDTH:1];
  assign dly_valid = dly_bus_s[0];

  // Coefficient fetch rides along with the delayed sample
  assign rom.en   = dly_valid;
  assign rom.addr = addr_cnt_r;

  // Step the coefficient address once per delayed valid sample, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt_r <= '0;
    end else if (dly_valid) begin
      addr_cnt_r <= addr_cnt_r + {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};
    end else begin
      addr_cnt_r <= addr_cnt_r;
    end
  end

  // Full-precision signed multiply, optional rounding, Q-scale shift and saturation
  always_comb begin
    prod_s = $signed({{DATA_WIDTH{dly_data[DATA_WIDTH-1]}}, dly_data})
           * $signed({{DATA_WIDTH{rom.data[DATA_WIDTH-1]}}, rom.data});
`ifdef DCT_ROUND_EN
    biased_s = prod_s + ROUND_BIAS;
`else
    biased_s = prod_s;
`endif
    shifted_s = biased_s >>> (DATA_WIDTH - 1);
    // Only (-1.0)*(-1.0) can exceed the positive range; negatives never underflow
    if (shifted_s > SAT_MAX_P) begin
      scaled_s = SAT_MAX_W;
    end else begin
      scaled_s = shifted_s[DATA_WIDTH-1:0];
    end
  end

  // Capture the product for valid samples and hold it across gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= dly_valid;
      if (dly_valid) begin
        out_data <= scaled_s;
      end else begin
        out_data <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_delayed_coef_multiplier.sv
// Directed self-checking bench for delayed_coef_multiplier (W=10, DEPTH=2, ADDR=3).
// Expected values are hand-computed; DCT_ROUND_EN selects the rounded expectations.
module tb_delayed_coef_multiplier;

  logic              clk;
  logic              rst_n;
  logic signed [9:0] in_data;
  logic              in_valid;
  logic signed [9:0] dly_data;
  logic              dly_valid;
  logic signed [9:0] out_data;
  logic              out_valid;
  logic signed [9:0] coef_drive;

  int checks;
  int failures;

`ifdef DCT_ROUND_EN
  localparam int EXP_POS   = 71;
  localparam int EXP_GAP_B = 141;
`else
  localparam int EXP_POS   = 70;
  localparam int EXP_GAP_B = 141;
`endif

  rom_if #(.ADDR_WIDTH(3), .DATA_WIDTH(10)) rom_bus ();

  // ROM model: constant coefficient per vector, zero while not enabled
  assign rom_bus.data = rom_bus.en ? coef_drive : 10'sd0;

  delayed_coef_multiplier #(
    .DATA_WIDTH (10),
    .DEPTH      (2),
    .ADDR_WIDTH (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .dly_data  (dly_data),
    .dly_valid (dly_valid),
    .rom       (rom_bus.tx),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated valid sample; checks the ROM request at +2 and the product at +3
  task automatic run_pulse(input string tag, input int din, input int coef,
                           input int exp_addr, input int exp_out);
    coef_drive = 10'(coef);
    in_data    = 10'(din);
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 10'sd0;
    tick();
    check({tag, "_rom_en"}, int'(rom_bus.en), 1);
    check({tag, "_rom_addr"}, int'(rom_bus.addr), exp_addr);
    check({tag, "_dly_data"}, int'(dly_data), din);
    tick();
    check({tag, "_out_valid"}, int'(out_valid), 1);
    check({tag, "_out_data"}, int'(out_data), exp_out);
    tick();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    in_data    = 10'sd0;
    in_valid   = 1'b0;
    coef_drive = 10'sd0;
    tick();
    tick();
    check("rst_dly_valid", int'(dly_valid), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_rom_en", int'(rom_bus.en), 0);
    check("rst_rom_addr", int'(rom_bus.addr), 0);
    rst_n = 1'b1;
    tick();

    run_pulse("pos", 100, 362, 0, EXP_POS);
    run_pulse("neg", -100, 362, 1, -71);
    run_pulse("sat", -512, -512, 2, 511);
    run_pulse("max", 511, 511, 3, 510);

    // Two samples in flight, then an asynchronous reset mid-cycle
    in_valid = 1'b1;
    in_data  = 10'sd55;
    tick();
    tick();
    check("pre_rst_dly_valid", int'(dly_valid), 1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_dly_valid", int'(dly_valid), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_rom_addr", int'(rom_bus.addr), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", int'(out_valid), 0);
    tick();
    check("post_rst_out_valid2", int'(out_valid), 0);

    // Nine back-to-back valids: addresses 0..7,0 and nine out_valid cycles
    coef_drive = 10'sd362;
    in_data    = 10'sd100;
    for (int t = 0; t < 13; t++) begin
      check($sformatf("burst_rom_en_t%0d", t), int'(rom_bus.en),
            (t >= 2 && t < 11) ? 1 : 0);
      if (t >= 2 && t < 11) begin
        check($sformatf("burst_rom_addr_t%0d", t), int'(rom_bus.addr), (t - 2) % 8);
      end
      check($sformatf("burst_out_valid_t%0d", t), int'(out_valid),
            (t >= 3 && t < 12) ? 1 : 0);
      in_valid = (t < 9) ? 1'b1 : 1'b0;
      tick();
    end
    in_valid = 1'b0;

    // Fresh start, then valid pattern 1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    in_data  = 10'sd100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("gap_addr_first", int'(rom_bus.addr), 0);
    check("gap_en_first", int'(rom_bus.en), 1);
    in_data  = 10'sd200;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("gap_out_a", int'(out_data), EXP_POS);
    check("gap_en_gap", int'(rom_bus.en), 0);
    check("gap_addr_gap", int'(rom_bus.addr), 1);
    tick();
    check("gap_out_hold", int'(out_data), EXP_POS);
    check("gap_out_valid_gap", int'(out_valid), 0);
    check("gap_addr_second", int'(rom_bus.addr), 1);
    check("gap_en_second", int'(rom_bus.en), 1);
    tick();
    check("gap_out_valid_b", int'(out_valid), 1);
    check("gap_out_b", int'(out_data), EXP_GAP_B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
